wb_arbiter: RTL and testbench

Writeback arbiter and write-port driver for the parameterized register file. Collects results from NUM_SRC functional units over valid/ready handshakes and holds each in a one-entry per-source buffer. Each cycle it grants up to NUM_WRITE held results in round-robin order and drives the register file's `w_en` / `w_addr` / `w_data` write ports. It is the writer-side counterpart that sits between execution-unit completion and the physical register file.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/rr_multi_grant.sv | 33 +++
 rtl/wb_arbiter.sv | 98 +++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback path: default widths and the
// round-robin pointer update used by the multi-grant arbiters.
package wb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_WRITE_DEF  = 4;
  localparam int NUM_SRC_DEF    = 6;
  localparam int MAX_SRC        = 32;

  // Pointer moves one past the last source granted in scan order from ptr.
  function automatic int rr_next(input logic [MAX_SRC-1:0] grant,
                                 input int ptr, input int num_src);
    int idx;
    int nxt;
    idx = 0;
    nxt = ptr;
    for (int k = 0; k < MAX_SRC; k++) begin
      if (k < num_src) begin
        idx = ptr + k;
        if (idx >= num_src) idx = idx - num_src;
        if (grant[idx]) nxt = (idx + 1 == num_src) ? 0 : idx + 1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin selector granting up to NUM_PORT requesters,
// scanning from ptr_i; also reports the port each grant lands on.
module rr_multi_grant #(
  parameter int NUM_SRC  = 6,
  parameter int NUM_PORT = 4,
  parameter int PTR_W    = 3,
  parameter int PORT_W   = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [PORT_W-1:0]  port_o [NUM_SRC]
);

  always_comb begin
    int cnt;
    int idx;
    cnt     = 0;
    idx     = 0;
    grant_o = '0;
    for (int i = 0; i < NUM_SRC; i++) port_o[i] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (req_i[idx] && cnt < NUM_PORT) begin
        grant_o[idx] = 1'b1;
        port_o[idx]  = PORT_W'(cnt);
        cnt          = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry buffer per result source, round-robin
// grant of up to NUM_WRITE buffers per cycle onto the register-file write ports.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_WRITE  = NUM_WRITE_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [ADDR_WIDTH-1:0] src_addr [NUM_SRC],
  input  logic [DATA_WIDTH-1:0] src_data [NUM_SRC],
  output logic [NUM_SRC-1:0]    src_ready,
  output logic [NUM_WRITE-1:0]  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr [NUM_WRITE],
  output logic [DATA_WIDTH-1:0] w_data [NUM_WRITE],
  output logic                  busy
);

  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PORT_W = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;

  logic [NUM_SRC-1:0]    held_q, held_d;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_SRC];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_SRC];
  logic [DATA_WIDTH-1:0] data_q [NUM_SRC];
  logic [DATA_WIDTH-1:0] data_d [NUM_SRC];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]    grant;
  logic [PORT_W-1:0]     port_idx [NUM_SRC];

  rr_multi_grant #(
    .NUM_SRC (NUM_SRC),
    .NUM_PORT(NUM_WRITE),
    .PTR_W   (PTR_W),
    .PORT_W  (PORT_W)
  ) u_grant (
    .req_i  (held_q),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .port_o (port_idx)
  );

  // A source being drained this cycle may refill in the same cycle.
  assign src_ready = reset ? '0 : (~held_q | grant);
  assign busy      = |held_q;

  always_comb begin
    held_d   = held_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rr_ptr_d = PTR_W'(rr_next(MAX_SRC'(grant), int'(rr_ptr_q), NUM_SRC));
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) begin
        held_d[i] = 1'b1;
        addr_d[i] = src_addr[i];
        data_d[i] = src_data[i];
      end else if (grant[i]) begin
        held_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_WRITE; k++) begin
      w_en[k]   = 1'b0;
      w_addr[k] = '0;
      w_data[k] = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!reset && grant[i] && int'(port_idx[i]) == k) begin
          w_en[k]   = 1'b1;
          w_addr[k] = addr_q[i];
          w_data[k] = data_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q   <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      held_q   <= held_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// cycle's write ports, ready and busy; a negedge monitor compares them.
module tb_wb_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NW = 4;
  localparam int NS = 6;

  typedef struct packed {
    logic [NW-1:0]    en;
    logic [NW*AW-1:0] addr;
    logic [NW*DW-1:0] data;
    logic [NS-1:0]    rdy;
    logic             busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] src_valid = '0;
  logic [AW-1:0] src_addr [NS];
  logic [DW-1:0] src_data [NS];
  logic [NS-1:0] src_ready;
  logic [NW-1:0] w_en;
  logic [AW-1:0] w_addr [NW];
  logic [DW-1:0] w_data [NW];
  logic          busy;

  wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WRITE(NW), .NUM_SRC(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .src_valid(src_valid),
    .src_addr (src_addr),
    .src_data (src_data),
    .src_ready(src_ready),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  bit            m_held [NS];
  logic [AW-1:0] m_addr [NS];
  logic [DW-1:0] m_data [NS];
  int            m_ptr = 0;

  logic          nrst;
  logic [NS-1:0] nv;
  logic [AW-1:0] na [NS];
  logic [DW-1:0] nd [NS];

  logic [DW-1:0] rf [32];
  bit            starv_on = 1'b0;
  int            gap [NS];
  int            maxgap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    int   gl[$];
    bit   g [NS];
    int   idx;
    @(posedge clk);
    #1;
    reset     = nrst;
    src_valid = nv;
    for (int i = 0; i < NS; i++) begin
      src_addr[i] = na[i];
      src_data[i] = nd[i];
    end
    e = '0;
    for (int i = 0; i < NS; i++) begin
      e.busy = e.busy | m_held[i];
      g[i]   = 1'b0;
    end
    if (nrst) begin
      for (int i = 0; i < NS; i++) begin
        m_held[i] = 1'b0;
        m_addr[i] = '0;
        m_data[i] = '0;
      end
      m_ptr = 0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        idx = (m_ptr + k) % NS;
        if (m_held[idx] && gl.size() < NW) gl.push_back(idx);
      end
      foreach (gl[j]) begin
        e.en[j]              = 1'b1;
        e.addr[j*AW +: AW]   = m_addr[gl[j]];
        e.data[j*DW +: DW]   = m_data[gl[j]];
        g[gl[j]]             = 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
        e.rdy[i] = !m_held[i] || g[i];
        if (nv[i] && e.rdy[i]) begin
          m_held[i] = 1'b1;
          m_addr[i] = na[i];
          m_data[i] = nd[i];
        end else if (g[i]) begin
          m_held[i] = 1'b0;
        end
      end
      if (gl.size() > 0) m_ptr = (gl[gl.size()-1] + 1) % NS;
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("w_en", 64'(w_en), 64'(e.en));
      for (int k = 0; k < NW; k++) begin
        chk($sformatf("w_addr%0d", k), 64'(w_addr[k]), 64'(e.addr[k*AW +: AW]));
        chk($sformatf("w_data%0d", k), 64'(w_data[k]), 64'(e.data[k*DW +: DW]));
      end
      chk("src_ready", 64'(src_ready), 64'(e.rdy));
      chk("busy", 64'(busy), 64'(e.busy));
      for (int k = 0; k < NW; k++)
        if (w_en[k] === 1'b1) rf[w_addr[k]] = w_data[k];
      if (starv_on) begin
        for (int s = 0; s < NS; s++) gap[s]++;
        for (int k = 0; k < NW; k++)
          if (w_en[k] === 1'b1 && int'(w_addr[k]) >= 16 && int'(w_addr[k]) < 16 + NS)
            gap[int'(w_addr[k]) - 16] = 0;
        for (int s = 0; s < NS; s++) if (gap[s] > maxgap) maxgap = gap[s];
      end
    end
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      src_addr[i] = '0;
      src_data[i] = '0;
      na[i] = '0;
      nd[i] = '0;
      m_held[i] = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
      gap[i] = 0;
    end
    for (int r = 0; r < 32; r++) rf[r] = '0;
    nrst = 1'b1;
    nv   = '0;
    step(); step();
    nrst = 1'b0;
    step();

    // single source
    nv = 6'b000100; na[2] = 5'd5; nd[2] = 8'hA3;
    step();
    nv = '0;
    step(); step();
    chk("rf5_single", 64'(rf[5]), 64'hA3);

    // overflow fairness from a fresh pointer
    nrst = 1'b1; step(); nrst = 1'b0;
    nv = '1;
    for (int i = 0; i < NS; i++) begin
      na[i] = AW'(i + 1);
      nd[i] = DW'(8'h40 + i);
    end
    step();
    nv = '0;
    step(); step(); step();
    for (int i = 0; i < NS; i++)
      chk($sformatf("rf%0d_overflow", i + 1), 64'(rf[i + 1]), 64'(8'h40 + i));

    // back-to-back streaming from source 0
    for (int c = 0; c < 8; c++) begin
      nv = 6'b000001; na[0] = AW'(8 + c); nd[0] = DW'(8'h10 + c);
      step();
    end
    nv = '0;
    step(); step();
    for (int c = 0; c < 8; c++)
      chk($sformatf("rf%0d_stream", 8 + c), 64'(rf[8 + c]), 64'(8'h10 + c));

    // simultaneous grant and reload on source 1
    nv = 6'b000010; na[1] = 5'd3; nd[1] = 8'h11;
    step();
    na[1] = 5'd4; nd[1] = 8'h22;
    step();
    nv = '0;
    step(); step();
    chk("rf3_reload", 64'(rf[3]), 64'h11);
    chk("rf4_reload", 64'(rf[4]), 64'h22);

    // reset while five buffers are held
    nv = 6'b011111;
    for (int i = 0; i < 5; i++) begin
      na[i] = AW'(20 + i);
      nd[i] = DW'(8'h80 + i);
    end
    step();
    nv = '0; nrst = 1'b1;
    step();
    nrst = 1'b0;
    step(); step();
    chk("busy_after_reset", 64'(busy), 64'h0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rf%0d_dropped", 20 + i), 64'(rf[20 + i]), 64'h0);

    // starvation: all sources permanently valid
    nv = '1;
    for (int i = 0; i < NS; i++) begin
      na[i] = AW'(16 + i);
      nd[i] = DW'($urandom());
    end
    step(); step();
    for (int s = 0; s < NS; s++) gap[s] = 0;
    maxgap = 0;
    starv_on = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NS; i++) nd[i] = DW'($urandom());
      step();
    end
    starv_on = 1'b0;
    chk("starve_gap_over_1", 64'(maxgap > 1), 64'h0);
    nv = '0;
    step(); step(); step();

    // randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      nrst = ($urandom_range(0, 59) == 0);
      nv   = NS'($urandom());
      for (int i = 0; i < NS; i++) begin
        na[i] = AW'($urandom());
        nd[i] = DW'($urandom());
      end
      step();
    end
    nrst = 1'b0;
    nv   = '0;
    repeat (4) step();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
